return_stack: RTL and testbench
===============================

# return_stack

Parametrised hardware return-address stack for the Reaper processor family. It is the successor to the fixed-depth stack file and generalises its width and depth. It adds occupancy reporting, separate sticky overflow/underflow flags, an atomic replace-top (push+pop) operation, and an optional wrap-around mode. It sits beside the program counter: it pushes PC+1 on calls and supplies the return address to the next-PC mux on returns, with zero-latency top-of-stack read.

## Interface
- DATA_W, 8, width of each stored entry (return address)
- DEPTH, 16, number of entries; power of two, ≥ 2
- Sys_Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- Push  in  1  push Push_Data this cycle
- Pop  in  1  pop top entry this cycle
- Push_Data  in  DATA_W  value to push
- Err_Clear  in  1  clears sticky error flags
- Top_Data  out  DATA_W  current top entry; 0 when empty
- Count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- Empty  out  1  Count == 0
- Full  out  1  Count == DEPTH
- Overflow_Err  out  1  sticky; push attempted while full (non-wrap mode only)
- Underflow_Err  out  1  sticky; pop attempted while empty

## Operation
- Storage is a DEPTH-entry circular array with a top pointer Sp (log2 DEPTH bits) and an occupancy counter Count.
- Occupancy states are derived from Count, not separately encoded: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- Operation is selected by {Push,Pop}:
  - NOP: no change.
  - PUSH: Sp+1, write Push_Data at new Sp, Count+1.
  - POP: Sp−1, Count−1.
  - REPLACE (Push & Pop): overwrite entry at Sp with Push_Data; Sp and Count unchanged. On EMPTY, REPLACE behaves as PUSH with no error.
- Sp arithmetic is modulo DEPTH; the pointer wraps silently.
- PUSH while FULL is handled per Configuration.
- POP while EMPTY: no state change, Underflow_Err ← 1.
- Error flags are sticky until Err_Clear. If an error event coincides with Err_Clear, the new event wins and the flag stays 1.
- Top_Data = array[Sp] when Count > 0, else 0.

## Timing
- Reset (Reset = 0 at a rising edge): Count=0, Sp=0, Empty=1, Full=0, Overflow_Err=0, Underflow_Err=0, Top_Data=0. Array contents are not cleared.
- Reset has priority over Push/Pop/Err_Clear in the same cycle. Reset mid-sequence discards all entries.
- Top_Data, Empty, Full and Count are combinational from registered state. A pop in cycle N uses the Top_Data visible in cycle N, as the next-PC mux needs. The post-pop top appears in cycle N+1.
- A push in cycle N makes Push_Data visible on Top_Data in cycle N+1.
- Error flags assert in the cycle after the offending edge.
- Throughput: one operation per cycle, no stalls.

## Configuration
- RETURN_STACK_WRAP_EN defined: PUSH while FULL overwrites the oldest entry. Sp advances, Count stays DEPTH, and Overflow_Err is never set. Deep recursion keeps the most recent DEPTH return addresses.
- Undefined: PUSH while FULL is dropped. Sp, Count and array are unchanged, and Overflow_Err ← 1.
- Underflow behaviour is identical in both modes.

## Structure
- Shared package reaper_stack_pkg:
  - rs_op_e enum (RS_NOP, RS_PUSH, RS_POP, RS_REPLACE), decoded from {Push,Pop}
  - default DATA_W/DEPTH localparams
  - the count-width function.
- One sub-module is natural: return_stack_mem. It holds the DEPTH×DATA_W register array with one synchronous write port and one asynchronous read port. Pointer, counter and flag logic stay in return_stack.

## Test plan
All scenarios use DEPTH=4, DATA_W=8.
- Reset, then push 0x11, 0x22, 0x33 → Count=3, Top_Data=0x33. Pop → Top_Data=0x22, Count=2.
- Fill with 0x11..0x44, then push 0x55:
  - Without macro → Overflow_Err=1, Count=4, Top_Data=0x44.
  - With RETURN_STACK_WRAP_EN → Overflow_Err=0, Top_Data=0x55; four pops yield 0x55, 0x44, 0x33, 0x22, then Empty=1.
- Pop on empty → Underflow_Err=1, Count=0, Top_Data=0x00. Err_Clear next cycle → Underflow_Err=0.
- Stack holds 0x11, 0x22; Push=Pop=1 with 0x99 → Top_Data=0x99, Count=2. Next pop → Top_Data=0x11. Replace on empty with 0x77 → Count=1, no error.
- Full stack, push (non-wrap) together with Err_Clear=1 → Overflow_Err stays 1.
- Count=3, Reset=0 with Push=1 → next cycle Count=0, Empty=1, flags 0, Top_Data=0x00.

Source files
------------

// File: rtl/reaper_stack_pkg.sv
// Shared types and sizing helpers for the Reaper return-address stack.
package reaper_stack_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Encoded directly as {Push,Pop}
  typedef enum logic [1:0] {
    RS_NOP     = 2'b00,
    RS_PUSH    = 2'b10,
    RS_POP     = 2'b01,
    RS_REPLACE = 2'b11
  } rs_op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/return_stack_if.sv
// Control/status bundle between the PC unit and the return stack.
interface return_stack_if
  import reaper_stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  logic                       Push;
  logic                       Pop;
  logic [DATA_W-1:0]          Push_Data;
  logic                       Err_Clear;
  logic [DATA_W-1:0]          Top_Data;
  logic [cnt_w(DEPTH)-1:0]    Count;
  logic                       Empty;
  logic                       Full;
  logic                       Overflow_Err;
  logic                       Underflow_Err;

  modport master (
    output Push, Pop, Push_Data, Err_Clear,
    input  Top_Data, Count, Empty, Full,
    input  Overflow_Err, Underflow_Err
  );

  modport slave (
    input  Push, Pop, Push_Data, Err_Clear,
    output Top_Data, Count, Empty, Full,
    output Overflow_Err, Underflow_Err
  );

endinterface

// File: rtl/return_stack_mem.sv
// Return-stack entry array: one synchronous write port, one async read port.
module return_stack_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Parametrised return-address stack with sticky error flags.
// Build option: RETURN_STACK_WRAP_EN makes push-while-full overwrite oldest.
module return_stack
  import reaper_stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic          Sys_Clock,
  input  logic          Reset,
  return_stack_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]     sp, sp_n, sp_inc, wr_addr;
  logic [CW-1:0]     count, count_n;
  logic              ovf, unf, ovf_ev, unf_ev;
  logic              wr_en, empty, full;
  logic [DATA_W-1:0] rd_data;
  rs_op_e            op;

  assign op     = rs_op_e'({bus.Push, bus.Pop});
  assign sp_inc = sp + PW'(1);
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  always_comb begin
    sp_n    = sp;
    count_n = count;
    wr_en   = 1'b0;
    wr_addr = sp_inc;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    unique case (1'b1)
      (op == RS_PUSH): begin
        if (!full) begin
          sp_n    = sp_inc;
          count_n = count + CW'(1);
          wr_en   = 1'b1;
        end else begin
`ifdef RETURN_STACK_WRAP_EN
          sp_n  = sp_inc;
          wr_en = 1'b1;
`else
          ovf_ev = 1'b1;
`endif
        end
      end
      (op == RS_POP): begin
        if (empty) begin
          unf_ev = 1'b1;
        end else begin
          sp_n    = sp - PW'(1);
          count_n = count - CW'(1);
        end
      end
      (op == RS_REPLACE): begin
        wr_en = 1'b1;
        if (empty) begin
          sp_n    = sp_inc;
          count_n = CW'(1);
        end else begin
          wr_addr = sp;
        end
      end
      default: ;
    endcase
  end

  // New error events win over a coincident clear
  always_ff @(posedge Sys_Clock) begin
    if (!Reset) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      sp    <= sp_n;
      count <= count_n;
      ovf   <= ovf_ev | (ovf & ~bus.Err_Clear);
      unf   <= unf_ev | (unf & ~bus.Err_Clear);
    end
  end

  return_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (Sys_Clock),
    .we    (wr_en & Reset),
    .waddr (wr_addr),
    .wdata (bus.Push_Data),
    .raddr (sp),
    .rdata (rd_data)
  );

  assign bus.Top_Data      = empty ? '0 : rd_data;
  assign bus.Count         = count;
  assign bus.Empty         = empty;
  assign bus.Full          = full;
  assign bus.Overflow_Err  = ovf;
  assign bus.Underflow_Err = unf;

endmodule

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack (DEPTH=4, DATA_W=8).
module tb_return_stack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  return_stack_if #(.DATA_W(8), .DEPTH(4)) bus ();

  return_stack #(.DATA_W(8), .DEPTH(4)) dut (
    .Sys_Clock (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic push, input logic pop,
                      input logic [7:0] d, input logic clr);
    bus.Push      = push;
    bus.Pop       = pop;
    bus.Push_Data = d;
    bus.Err_Clear = clr;
    @(posedge clk);
    #1;
    bus.Push      = 1'b0;
    bus.Pop       = 1'b0;
    bus.Err_Clear = 1'b0;
  endtask

  initial begin
    bus.Push = 0; bus.Pop = 0; bus.Push_Data = 0; bus.Err_Clear = 0;
    rst = 1'b0;
    step(1, 0, 8'hAA, 1);
    chk("rst_count", 32'(bus.Count), 0);
    chk("rst_empty", 32'(bus.Empty), 1);
    chk("rst_full", 32'(bus.Full), 0);
    chk("rst_ovf", 32'(bus.Overflow_Err), 0);
    chk("rst_unf", 32'(bus.Underflow_Err), 0);
    chk("rst_top", 32'(bus.Top_Data), 0);
    rst = 1'b1;

    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    chk("push3_count", 32'(bus.Count), 3);
    chk("push3_top", 32'(bus.Top_Data), 32'h33);
    step(0, 1, 8'h00, 0);
    chk("pop_top", 32'(bus.Top_Data), 32'h22);
    chk("pop_count", 32'(bus.Count), 2);

    step(1, 0, 8'h33, 0);
    step(1, 0, 8'h44, 0);
    chk("fill_count", 32'(bus.Count), 4);
    chk("fill_full", 32'(bus.Full), 1);
    step(1, 0, 8'h55, 0);
`ifdef RETURN_STACK_WRAP_EN
    chk("wrap_ovf", 32'(bus.Overflow_Err), 0);
    chk("wrap_top", 32'(bus.Top_Data), 32'h55);
    chk("wrap_count", 32'(bus.Count), 4);
    chk("wrap_pop0", 32'(bus.Top_Data), 32'h55);
    step(0, 1, 8'h00, 0);
    chk("wrap_pop1", 32'(bus.Top_Data), 32'h44);
    step(0, 1, 8'h00, 0);
    chk("wrap_pop2", 32'(bus.Top_Data), 32'h33);
    step(0, 1, 8'h00, 0);
    chk("wrap_pop3", 32'(bus.Top_Data), 32'h22);
    step(0, 1, 8'h00, 0);
    chk("wrap_empty", 32'(bus.Empty), 1);
`else
    chk("ovf_flag", 32'(bus.Overflow_Err), 1);
    chk("ovf_count", 32'(bus.Count), 4);
    chk("ovf_top", 32'(bus.Top_Data), 32'h44);
    step(1, 0, 8'h66, 1);
    chk("ovf_vs_clr", 32'(bus.Overflow_Err), 1);
    chk("ovf_vs_clr_top", 32'(bus.Top_Data), 32'h44);
    step(0, 0, 8'h00, 1);
    chk("ovf_clr", 32'(bus.Overflow_Err), 0);
    step(0, 1, 8'h00, 0);
    chk("drain1", 32'(bus.Top_Data), 32'h33);
    step(0, 1, 8'h00, 0);
    chk("drain2", 32'(bus.Top_Data), 32'h22);
    step(0, 1, 8'h00, 0);
    chk("drain3", 32'(bus.Top_Data), 32'h11);
    step(0, 1, 8'h00, 0);
    chk("drain_empty", 32'(bus.Empty), 1);
`endif

    step(0, 1, 8'h00, 0);
    chk("unf_flag", 32'(bus.Underflow_Err), 1);
    chk("unf_count", 32'(bus.Count), 0);
    chk("unf_top", 32'(bus.Top_Data), 0);
    step(0, 0, 8'h00, 1);
    chk("unf_clr", 32'(bus.Underflow_Err), 0);

    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 1, 8'h99, 0);
    chk("repl_top", 32'(bus.Top_Data), 32'h99);
    chk("repl_count", 32'(bus.Count), 2);
    step(0, 1, 8'h00, 0);
    chk("repl_pop", 32'(bus.Top_Data), 32'h11);
    step(0, 1, 8'h00, 0);
    chk("repl_drain", 32'(bus.Empty), 1);
    step(1, 1, 8'h77, 0);
    chk("repl_empty_count", 32'(bus.Count), 1);
    chk("repl_empty_top", 32'(bus.Top_Data), 32'h77);
    chk("repl_empty_unf", 32'(bus.Underflow_Err), 0);
    chk("repl_empty_ovf", 32'(bus.Overflow_Err), 0);

    step(1, 0, 8'hA1, 0);
    step(1, 0, 8'hA2, 0);
    chk("pre_rst_count", 32'(bus.Count), 3);
    chk("pre_rst_top", 32'(bus.Top_Data), 32'hA2);
    rst = 1'b0;
    step(1, 0, 8'hB0, 0);
    rst = 1'b1;
    chk("mid_rst_count", 32'(bus.Count), 0);
    chk("mid_rst_empty", 32'(bus.Empty), 1);
    chk("mid_rst_top", 32'(bus.Top_Data), 0);
    chk("mid_rst_ovf", 32'(bus.Overflow_Err), 0);
    chk("mid_rst_unf", 32'(bus.Underflow_Err), 0);
    step(1, 0, 8'hC3, 0);
    chk("post_rst_top", 32'(bus.Top_Data), 32'hC3);
    chk("post_rst_count", 32'(bus.Count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
